// File: rtl/branch_ctrl_if.sv
// EX-resolution and fetch-redirect bundle for branch_ctrl.
// master = pipeline side (EX stage + fetch), slave = branch_ctrl.
interface branch_ctrl_if #(
   parameter int XLEN = 32
);
   logic            ex_valid;
   logic            ex_ready;
   logic            ex_branch;
   logic            ex_jump;
   logic            ex_taken;
   logic            ex_pred_taken;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_target;
   logic            flush;
   logic            redirect_valid;
   logic            redirect_ready;
   logic [XLEN-1:0] redirect_pc;

   modport master (
      output ex_valid, ex_branch, ex_jump, ex_taken, ex_pred_taken, ex_pc, ex_target,
      output redirect_ready,
      input  ex_ready, flush, redirect_valid, redirect_pc
   );

   modport slave (
      input  ex_valid, ex_branch, ex_jump, ex_taken, ex_pred_taken, ex_pc, ex_target,
      input  redirect_ready,
      output ex_ready, flush, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/branch_ctrl.sv
// Branch resolution controller: 2-bit BHT, mispredict check, flush + redirect to fetch.
// Optional BRANCH_STATS_EN adds stat_branches / stat_mispredicts counters.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | ready for a resolution request from EX
// S_REDIRECT | mispredict seen; redirect_pc offered to fetch, EX stalled
module branch_ctrl #(
   parameter int BHT_IDX_W = 6,
   parameter int XLEN      = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] if_pc,
   output logic            if_pred_taken,
   branch_ctrl_if.slave    bus
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
`endif
);

   localparam int BHT_ENTRIES = 1 << BHT_IDX_W;

   typedef enum logic {
      S_IDLE,
      S_REDIRECT
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            bht [BHT_ENTRIES];
   logic [BHT_IDX_W-1:0]  if_idx;
   logic [BHT_IDX_W-1:0]  ex_idx;
   logic [1:0]            ctr_cur, ctr_nxt;
   logic                  accept;
   logic                  is_ctrl;
   logic                  actual;
   logic                  mispredict;
   logic [XLEN-1:0]       correct_pc;
   logic                  flush_q;
   logic [XLEN-1:0]       redirect_pc_q;
   logic                  unused_ok;

   assign if_idx = if_pc[BHT_IDX_W+1:2];
   assign ex_idx = bus.ex_pc[BHT_IDX_W+1:2];

   // Read before any same-cycle write lands: lookup sees the pre-update counter.
   assign if_pred_taken = bht[if_idx][1];

   assign unused_ok = ^{if_pc[XLEN-1:BHT_IDX_W+2], if_pc[1:0]};

   assign is_ctrl    = bus.ex_branch | bus.ex_jump;
   assign actual     = bus.ex_jump | (bus.ex_branch & bus.ex_taken);
   assign correct_pc = actual ? bus.ex_target : bus.ex_pc + XLEN'(4);

   always_comb begin
      ctr_cur = bht[ex_idx];
      ctr_nxt = ctr_cur;
      if (bus.ex_taken) begin
         if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'd1;
      end else begin
         if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      bus.ex_ready = 1'b0;
      accept       = 1'b0;
      mispredict   = 1'b0;
      case (state_q)
         S_IDLE: begin
            bus.ex_ready = 1'b1;
            accept       = bus.ex_valid;
            mispredict   = accept & is_ctrl & (actual != bus.ex_pred_taken);
            if (mispredict) state_d = S_REDIRECT;
         end
         S_REDIRECT: begin
            if (bus.redirect_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
      end else if (accept && bus.ex_branch) begin
         bht[ex_idx] <= ctr_nxt;
      end
   end

   // redirect_pc only loads on a mispredict, so it stays stable through the REDIRECT stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_q       <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         flush_q <= mispredict;
         if (mispredict) redirect_pc_q <= correct_pc;
      end
   end

   assign bus.flush          = flush_q;
   assign bus.redirect_valid = (state_q == S_REDIRECT);
   assign bus.redirect_pc    = redirect_pc_q;

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (accept && is_ctrl) stat_branches    <= stat_branches + 32'd1;
         if (mispredict)        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus random resolutions
// checked against a counter-table reference model.
module tb_branch_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] if_pc;
   logic        if_pred_taken;
`ifdef BRANCH_STATS_EN
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;
`endif

   branch_ctrl_if #(.XLEN(32)) bus ();

   branch_ctrl #(.BHT_IDX_W(6), .XLEN(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .if_pc            (if_pc),
      .if_pred_taken    (if_pred_taken),
      .bus              (bus)
`ifdef BRANCH_STATS_EN
      ,
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          m_ctr [64];
   int unsigned m_br;
   int unsigned m_mis;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_ctr[i] = 1;
      m_br  = 0;
      m_mis = 0;
   endtask

   function automatic logic model_pred(input logic [31:0] pc);
      return (m_ctr[pc[7:2]] >= 2);
   endfunction

   task automatic check_lookup(input string tag, input logic [31:0] pc);
      if_pc = pc;
      #1;
      chk(tag, {31'd0, if_pred_taken}, {31'd0, model_pred(pc)});
   endtask

   task automatic check_stats();
`ifdef BRANCH_STATS_EN
      chk("stat_branches", stat_branches, m_br);
      chk("stat_mispredicts", stat_mispredicts, m_mis);
`endif
   endtask

   // One resolution request; a mispredict is acknowledged after ack_dly stall cycles,
   // during which junk requests are presented to confirm they are ignored.
   task automatic resolve(input bit br, input bit jmp, input bit tkn, input bit prd,
                          input logic [31:0] pc, input logic [31:0] tgt, input int ack_dly);
      bit          actual, mis, ctl;
      logic [31:0] cpc;
      int          idx;
      @(posedge clk); #1;
      idx    = int'(pc[7:2]);
      ctl    = br | jmp;
      actual = jmp | (br & tkn);
      mis    = ctl && (actual != prd);
      cpc    = actual ? tgt : pc + 32'd4;
      bus.ex_valid      = 1'b1;
      bus.ex_branch     = br;
      bus.ex_jump       = jmp;
      bus.ex_taken      = tkn;
      bus.ex_pred_taken = prd;
      bus.ex_pc         = pc;
      bus.ex_target     = tgt;
      if_pc             = pc;
      @(negedge clk);
      chk("ex_ready_idle", {31'd0, bus.ex_ready}, 32'd1);
      chk("pred_pre_update", {31'd0, if_pred_taken}, {31'd0, model_pred(pc)});
      @(posedge clk); #1;
      if (br) m_ctr[idx] = tkn ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                               : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
      if (ctl) m_br++;
      if (mis) m_mis++;
      bus.ex_valid      = mis;
      bus.ex_branch     = 1'b1;
      bus.ex_jump       = $urandom_range(0, 1);
      bus.ex_taken      = $urandom_range(0, 1);
      bus.ex_pred_taken = $urandom_range(0, 1);
      bus.ex_target     = $urandom;
      @(negedge clk);
      chk("flush_after_accept", {31'd0, bus.flush}, {31'd0, mis});
      chk("redirect_valid_after_accept", {31'd0, bus.redirect_valid}, {31'd0, mis});
      chk("ex_ready_after_accept", {31'd0, bus.ex_ready}, {31'd0, !mis});
      chk("pred_post_update", {31'd0, if_pred_taken}, {31'd0, model_pred(pc)});
      if (mis) begin
         chk("redirect_pc", bus.redirect_pc, cpc);
         for (int i = 0; i < ack_dly; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("flush_single_cycle", {31'd0, bus.flush}, 32'd0);
            chk("redirect_valid_hold", {31'd0, bus.redirect_valid}, 32'd1);
            chk("redirect_pc_hold", bus.redirect_pc, cpc);
            chk("ex_ready_stall", {31'd0, bus.ex_ready}, 32'd0);
         end
         bus.redirect_ready = 1'b1;
         @(posedge clk); #1;
         bus.redirect_ready = 1'b0;
         bus.ex_valid       = 1'b0;
         @(negedge clk);
         chk("redirect_valid_cleared", {31'd0, bus.redirect_valid}, 32'd0);
         chk("ex_ready_back", {31'd0, bus.ex_ready}, 32'd1);
         chk("flush_idle", {31'd0, bus.flush}, 32'd0);
      end
      check_stats();
   endtask

   initial begin
      bit          br, jmp, tkn, prd;
      int          sel;
      logic [31:0] pc;

      rst                = 1'b1;
      if_pc              = 32'h100;
      bus.ex_valid       = 1'b0;
      bus.ex_branch      = 1'b0;
      bus.ex_jump        = 1'b0;
      bus.ex_taken       = 1'b0;
      bus.ex_pred_taken  = 1'b0;
      bus.ex_pc          = '0;
      bus.ex_target      = '0;
      bus.redirect_ready = 1'b0;
      model_reset();

      // Scenario 1: reset state
      #2;
      chk("rst_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
      chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_pred_0x100", {31'd0, if_pred_taken}, 32'd0);
      chk("rst_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
      chk("rst_flush", {31'd0, bus.flush}, 32'd0);
      check_stats();

      // Scenario 2: taken branch at 0x100, predicted not-taken, three times
      for (int i = 0; i < 3; i++) begin
         resolve(1, 0, 1, 0, 32'h100, 32'h200, i);
         check_lookup("s2_pred_0x100", 32'h100);
      end
      chk("s2_pred_saturated", {31'd0, if_pred_taken}, 32'd1);

      // Scenario 3: not-taken at 0x80 predicted taken, long redirect stall
      resolve(1, 0, 0, 1, 32'h80, 32'h300, 5);
      // Scenario 4: correct prediction
      resolve(1, 0, 1, 1, 32'h100, 32'h200, 0);
      // Scenario 5: fall-through wraps past the top of the address space
      resolve(1, 0, 0, 1, 32'hFFFF_FFFC, 32'h400, 1);
      // Jump, non-branch request, jump that was predicted
      resolve(0, 1, 0, 0, 32'h40, 32'h800, 2);
      resolve(0, 0, 1, 0, 32'h44, 32'h900, 0);
      resolve(0, 1, 1, 1, 32'h48, 32'hA00, 0);

      // Random resolutions against the reference model
      for (int n = 0; n < 60; n++) begin
         pc  = 32'h1000 + ({29'd0, 3'($urandom_range(0, 7))} << 2);
         sel = $urandom_range(0, 4);
         br  = (sel >= 2);
         jmp = (sel == 1);
         tkn = $urandom_range(0, 1);
         prd = model_pred(pc) ^ ($urandom_range(0, 2) == 0);
         resolve(br, jmp, tkn, prd, pc, $urandom, $urandom_range(0, 3));
         check_lookup("rand_lookup", 32'h1000 + ({29'd0, 3'($urandom_range(0, 7))} << 2));
      end

      // Scenario 6: reset asserted during REDIRECT
      @(posedge clk); #1;
      bus.ex_valid      = 1'b1;
      bus.ex_branch     = 1'b1;
      bus.ex_jump       = 1'b0;
      bus.ex_taken      = 1'b1;
      bus.ex_pred_taken = 1'b0;
      bus.ex_pc         = 32'h100;
      bus.ex_target     = 32'h200;
      @(posedge clk); #1;
      bus.ex_valid = 1'b0;
      @(negedge clk);
      chk("s6_in_redirect", {31'd0, bus.redirect_valid}, 32'd1);
      rst = 1'b1;
      model_reset();
      #1;
      chk("s6_redirect_valid_async", {31'd0, bus.redirect_valid}, 32'd0);
      chk("s6_flush_async", {31'd0, bus.flush}, 32'd0);
      chk("s6_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
      check_lookup("s6_pred_0x100", 32'h100);
      check_lookup("s6_pred_0x1000", 32'h1000);
      check_lookup("s6_pred_0xFFFFFFFC", 32'hFFFF_FFFC);
      check_stats();
      @(negedge clk);
      rst = 1'b0;
      resolve(1, 0, 1, 0, 32'h100, 32'h200, 0);
      check_lookup("s6_post_reset_pred", 32'h100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
